// File: rtl/brt_usb_20_utmi_rx_pkg.sv
// Shared types and constants for the UTMI receive packet decoder.
package brt_usb_20_utmi_rx_pkg;

    typedef enum logic [3:0] {
        PID_EXT   = 4'h0, PID_OUT   = 4'h1, PID_ACK   = 4'h2, PID_DATA0 = 4'h3,
        PID_PING  = 4'h4, PID_SOF   = 4'h5, PID_NYET  = 4'h6, PID_DATA2 = 4'h7,
        PID_SPLIT = 4'h8, PID_IN    = 4'h9, PID_NAK   = 4'hA, PID_DATA1 = 4'hB,
        PID_PRE   = 4'hC, PID_SETUP = 4'hD, PID_STALL = 4'hE, PID_MDATA = 4'hF
    } pid_e;

    typedef enum logic [1:0] {CLS_TOKEN, CLS_DATA, CLS_HS, CLS_OTHER} cls_e;

    typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_BODY, ST_DRAIN, ST_DONE} state_e;

    localparam int ERR_RX  = 0;
    localparam int ERR_PID = 1;
    localparam int ERR_LEN = 2;
    localparam int ERR_CRC = 3;

    localparam logic [4:0]  CRC5_POLY   = 5'h05;
    localparam logic [4:0]  CRC5_INIT   = 5'h1F;
    localparam logic [4:0]  CRC5_RESID  = 5'h0C;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESID = 16'h800D;

    function automatic cls_e pid_class(input logic [3:0] pid);
        cls_e cls;
        case (pid_e'(pid))
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:        cls = CLS_DATA;
            PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_PING:      cls = CLS_TOKEN;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:              cls = CLS_HS;
            default:                                            cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    function automatic logic pid_ok(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

endpackage

// File: rtl/brt_usb_20_crc_step.sv
// Byte-wide USB CRC LFSR update, data bits consumed LSB first.
module brt_usb_20_crc_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = '0
) (
    input  logic [WIDTH-1:0] crc_in,
    input  logic [7:0]       data_in,
    output logic [WIDTH-1:0] crc_out
);
    logic [WIDTH-1:0] stage [0:8];

    assign stage[0] = crc_in;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            logic fb;
            assign fb            = stage[gi][WIDTH-1] ^ data_in[gi];
            assign stage[gi + 1] = {stage[gi][WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    endgenerate

    assign crc_out = stage[8];
endmodule

// File: rtl/brt_usb_20_utmi_rx_pkt.sv
// UTMI receive packet decoder: PID check, class/length/CRC checks, CRC16 stripping.
// Define BRT_USB_20_UTMI_RX_CRC_EN to compile in the CRC5/CRC16 checkers.
module brt_usb_20_utmi_rx_pkt
    import brt_usb_20_utmi_rx_pkg::*;
#(
    parameter int MAX_BYTES = 1027,
    parameter int LEN_W     = 11
) (
    input  logic             clk_utmi,
    input  logic             rst_utmi,
    input  logic [15:0]      utmidatao,
    input  logic             utmirxvalid,
    input  logic             utmirxactive,
    input  logic             utmirxerror,
    output logic             pkt_valid,
    output logic [7:0]       pkt_data,
    output logic             pkt_sop,
    output logic             pkt_pid_valid,
    output logic [3:0]       pkt_pid,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_len,
    output logic [3:0]       pkt_err
);
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_BYTES);

    state_e           state_q, state_d;
    logic             rxactive_q, rxactive_d;
    logic             start_pend_q, start_pend_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [3:0]       err_q, err_d;
    cls_e             cls_q, cls_d;
    logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d;
    logic [1:0]       hold_cnt_q, hold_cnt_d;
    logic             valid_q, valid_d, sop_q, sop_d, pidv_q, pidv_d, done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       pid_q, pid_d, err_out_q, err_out_d;
    logic [LEN_W-1:0] len_out_q, len_out_d;

    logic [7:0] byte_in, fwd_byte, unused_hi;
    logic       byte_acc, rise, body_acc, crc_bad, fwd;

    assign byte_in   = utmidatao[7:0];
    assign unused_hi = utmidatao[15:8];
    assign byte_acc  = utmirxvalid & utmirxactive & ~utmirxerror;
    assign rise      = utmirxactive & ~rxactive_q;
    assign body_acc  = (state_q == ST_BODY) && byte_acc && (cnt_q != MAX_CNT);

`ifdef BRT_USB_20_UTMI_RX_CRC_EN
    logic [4:0]  crc5_q, crc5_d, crc5_nxt;
    logic [15:0] crc16_q, crc16_d, crc16_nxt;

    brt_usb_20_crc_step #(.WIDTH(5), .POLY(CRC5_POLY)) u_crc5 (
        .crc_in  (crc5_q),
        .data_in (byte_in),
        .crc_out (crc5_nxt)
    );

    brt_usb_20_crc_step #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
        .crc_in  (crc16_q),
        .data_in (byte_in),
        .crc_out (crc16_nxt)
    );

    always_comb begin
        crc5_d  = crc5_q;
        crc16_d = crc16_q;
        if (state_q == ST_IDLE) begin
            crc5_d  = CRC5_INIT;
            crc16_d = CRC16_INIT;
        end else if (body_acc) begin
            crc5_d  = crc5_nxt;
            crc16_d = crc16_nxt;
        end
    end

    always_ff @(posedge clk_utmi) begin
        if (rst_utmi) begin
            crc5_q  <= '0;
            crc16_q <= '0;
        end else begin
            crc5_q  <= crc5_d;
            crc16_q <= crc16_d;
        end
    end

    assign crc_bad = ((cls_q == CLS_TOKEN) && (crc5_q != CRC5_RESID)) ||
                     ((cls_q == CLS_DATA)  && (crc16_q != CRC16_RESID));
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rxactive_d   = utmirxactive;
        start_pend_d = start_pend_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        err_d        = err_q;
        cls_d        = cls_q;
        hold0_d      = hold0_q;
        hold1_d      = hold1_q;
        hold_cnt_d   = hold_cnt_q;
        valid_d      = 1'b0;
        sop_d        = 1'b0;
        pidv_d       = 1'b0;
        done_d       = 1'b0;
        data_d       = data_q;
        pid_d        = pid_q;
        err_out_d    = err_out_q;
        len_out_d    = len_out_q;
        fwd          = 1'b0;
        fwd_byte     = byte_in;

        case (state_q)
            ST_IDLE: begin
                if (rise || start_pend_q) begin
                    state_d      = ST_PID;
                    start_pend_d = 1'b0;
                    cnt_d        = '0;
                    len_d        = '0;
                    err_d        = '0;
                    cls_d        = CLS_OTHER;
                    hold0_d      = '0;
                    hold1_d      = '0;
                    hold_cnt_d   = '0;
                end
            end
            ST_PID: begin
                if (!utmirxactive) begin
                    err_d[ERR_LEN] = 1'b1;
                    state_d        = ST_DONE;
                end else if (utmirxerror) begin
                    err_d[ERR_RX] = 1'b1;
                    state_d       = ST_DRAIN;
                end else if (byte_acc) begin
                    cnt_d = LEN_W'(1);
                    if (pid_ok(byte_in)) begin
                        pid_d   = byte_in[3:0];
                        pidv_d  = 1'b1;
                        cls_d   = pid_class(byte_in[3:0]);
                        state_d = ST_BODY;
                    end else begin
                        err_d[ERR_PID] = 1'b1;
                        state_d        = ST_DRAIN;
                    end
                end
            end
            ST_BODY: begin
                if (!utmirxactive) begin
                    unique case (cls_q)
                        CLS_TOKEN: if (cnt_q != LEN_W'(3)) err_d[ERR_LEN] = 1'b1;
                        CLS_DATA:  if (cnt_q < LEN_W'(3))  err_d[ERR_LEN] = 1'b1;
                        CLS_HS:    if (cnt_q != LEN_W'(1)) err_d[ERR_LEN] = 1'b1;
                        default: ;
                    endcase
                    if (crc_bad) err_d[ERR_CRC] = 1'b1;
                    state_d = ST_DONE;
                end else if (utmirxerror) begin
                    err_d[ERR_RX] = 1'b1;
                    state_d       = ST_DRAIN;
                end else if (byte_acc) begin
                    if (!body_acc) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        // Data bytes trail by two so the CRC16 never leaves the hold register.
                        if (cls_q == CLS_DATA) begin
                            if (hold_cnt_q == 2'd2) begin
                                fwd      = 1'b1;
                                fwd_byte = hold0_q;
                            end else begin
                                hold_cnt_d = hold_cnt_q + 2'd1;
                            end
                            hold0_d = hold1_q;
                            hold1_d = byte_in;
                        end else begin
                            fwd = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!utmirxactive) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (rise) start_pend_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fwd) begin
            valid_d = 1'b1;
            data_d  = fwd_byte;
            sop_d   = (len_q == '0);
            len_d   = len_q + LEN_W'(1);
        end

        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d    = 1'b1;
            len_out_d = len_q;
            err_out_d = err_d;
        end
    end

    always_ff @(posedge clk_utmi) begin
        if (rst_utmi) begin
            state_q      <= ST_IDLE;
            rxactive_q   <= 1'b1;
            start_pend_q <= 1'b0;
            cnt_q        <= '0;
            len_q        <= '0;
            err_q        <= '0;
            cls_q        <= CLS_OTHER;
            hold0_q      <= '0;
            hold1_q      <= '0;
            hold_cnt_q   <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            pidv_q       <= 1'b0;
            done_q       <= 1'b0;
            data_q       <= '0;
            pid_q        <= '0;
            err_out_q    <= '0;
            len_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            rxactive_q   <= rxactive_d;
            start_pend_q <= start_pend_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            err_q        <= err_d;
            cls_q        <= cls_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
            hold_cnt_q   <= hold_cnt_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            pidv_q       <= pidv_d;
            done_q       <= done_d;
            data_q       <= data_d;
            pid_q        <= pid_d;
            err_out_q    <= err_out_d;
            len_out_q    <= len_out_d;
        end
    end

    assign pkt_valid     = valid_q;
    assign pkt_data      = data_q;
    assign pkt_sop       = sop_q;
    assign pkt_pid_valid = pidv_q;
    assign pkt_pid       = pid_q;
    assign pkt_done      = done_q;
    assign pkt_len       = len_out_q;
    assign pkt_err       = err_out_q;
endmodule

// File: tb/tb_brt_usb_20_utmi_rx_pkt.sv
// Directed bench for the UTMI receive packet decoder (default and MAX_BYTES=8 instances).
module tb_brt_usb_20_utmi_rx_pkt;
    localparam int LEN_W = 11;

`ifdef BRT_USB_20_UTMI_RX_CRC_EN
    localparam int CRC_ERR = 8;
`else
    localparam int CRC_ERR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] utmidatao = '0;
    logic        utmirxvalid = 1'b0, utmirxactive = 1'b0, utmirxerror = 1'b0;

    logic             pkt_valid, pkt_sop, pkt_pid_valid, pkt_done;
    logic [7:0]       pkt_data;
    logic [3:0]       pkt_pid, pkt_err;
    logic [LEN_W-1:0] pkt_len;

    logic             d8_valid, d8_sop, d8_pid_valid, d8_done;
    logic [7:0]       d8_data;
    logic [3:0]       d8_pid, d8_err;
    logic [LEN_W-1:0] d8_len;

    brt_usb_20_utmi_rx_pkt #(.MAX_BYTES(1027), .LEN_W(LEN_W)) dut (
        .clk_utmi(clk), .rst_utmi(rst), .utmidatao(utmidatao),
        .utmirxvalid(utmirxvalid), .utmirxactive(utmirxactive), .utmirxerror(utmirxerror),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_sop(pkt_sop),
        .pkt_pid_valid(pkt_pid_valid), .pkt_pid(pkt_pid), .pkt_done(pkt_done),
        .pkt_len(pkt_len), .pkt_err(pkt_err)
    );

    brt_usb_20_utmi_rx_pkt #(.MAX_BYTES(8), .LEN_W(LEN_W)) dut8 (
        .clk_utmi(clk), .rst_utmi(rst), .utmidatao(utmidatao),
        .utmirxvalid(utmirxvalid), .utmirxactive(utmirxactive), .utmirxerror(utmirxerror),
        .pkt_valid(d8_valid), .pkt_data(d8_data), .pkt_sop(d8_sop),
        .pkt_pid_valid(d8_pid_valid), .pkt_pid(d8_pid), .pkt_done(d8_done),
        .pkt_len(d8_len), .pkt_err(d8_err)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    initial forever begin
        #5 clk = 1'b1;
        cyc++;
        #5 clk = 1'b0;
    end

    // Monitor state, sampled on the falling edge.
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int sop_cnt, sop_idx, pidv_cnt, pidv_cyc, done_cnt, done_cyc, late_cnt, first_valid_cyc;
    int done_len_a[4], done_err_a[4];
    int d8_done_cnt, d8_len_last, d8_err_last;
    bit seen_done;
    int drive_cyc[128];
    int low_cyc;

    initial forever begin
        @(negedge clk);
        if (pkt_valid) begin
            if (pkt_sop) begin
                sop_cnt++;
                sop_idx = rx_q.size();
            end
            if (rx_q.size() == 0) first_valid_cyc = cyc;
            if (pkt_done || seen_done) late_cnt++;
            rx_q.push_back(pkt_data);
        end
        if (pkt_pid_valid) begin
            pidv_cnt++;
            pidv_cyc  = cyc;
            seen_done = 1'b0;
        end
        if (pkt_done) begin
            if (done_cnt < 4) begin
                done_len_a[done_cnt] = int'(pkt_len);
                done_err_a[done_cnt] = int'(pkt_err);
            end
            done_cnt++;
            done_cyc  = cyc;
            seen_done = 1'b1;
        end
        if (d8_done) begin
            d8_done_cnt++;
            d8_len_last = int'(d8_len);
            d8_err_last = int'(d8_err);
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        sop_cnt = 0; sop_idx = -1; pidv_cnt = 0; pidv_cyc = -1;
        done_cnt = 0; done_cyc = -1; late_cnt = 0; first_valid_cyc = -1;
        d8_done_cnt = 0; d8_len_last = -1; d8_err_last = -1;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            done_len_a[i] = -1;
            done_err_a[i] = -1;
        end
    endtask

    // rxactive rises, two quiet cycles, then one byte per cycle, then rxactive drops.
    task automatic send_pkt(input int err_at);
        @(posedge clk); #1;
        utmirxactive = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < tx_q.size(); i++) begin
            utmirxvalid = 1'b1;
            utmidatao   = {8'hA5, tx_q[i]};
            utmirxerror = (i == err_at);
            if (i < 128) drive_cyc[i] = cyc;
            @(posedge clk); #1;
        end
        utmirxvalid  = 1'b0;
        utmirxerror  = 1'b0;
        utmirxactive = 1'b0;
        low_cyc      = cyc;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [15:0] crc;
        logic [7:0]  pay [64];
        logic [7:0]  c0, c1;
        logic        fb;

        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_flags", int'({pkt_valid, pkt_sop, pkt_pid_valid, pkt_done}), 0);
        check_val("rst_pid", int'(pkt_pid), 0);
        check_val("rst_len", int'(pkt_len), 0);
        check_val("rst_err", int'(pkt_err), 0);

        // ACK handshake
        clear_mon(); tx_q = '{8'hD2}; send_pkt(-1); settle();
        check_val("ack_done_cnt", done_cnt, 1);
        check_val("ack_pid", int'(pkt_pid), 2);
        check_val("ack_len", done_len_a[0], 0);
        check_val("ack_err", done_err_a[0], 0);
        check_val("ack_valid_cnt", rx_q.size(), 0);
        check_val("ack_pidv_lat", pidv_cyc, drive_cyc[0] + 1);
        check_val("ack_done_lat", done_cyc, low_cyc + 1);

        // SETUP token addr 0 endp 0
        clear_mon(); tx_q = '{8'h2D, 8'h00, 8'h10}; send_pkt(-1); settle();
        check_val("setup_cnt", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check_val("setup_b0", int'(rx_q[0]), 8'h00);
            check_val("setup_b1", int'(rx_q[1]), 8'h10);
        end
        check_val("setup_sop_cnt", sop_cnt, 1);
        check_val("setup_sop_idx", sop_idx, 0);
        check_val("setup_valid_lat", first_valid_cyc, drive_cyc[1] + 1);
        check_val("setup_pid", int'(pkt_pid), 4'hD);
        check_val("setup_len", done_len_a[0], 2);
        check_val("setup_err", done_err_a[0], 0);

        // SETUP with corrupted CRC5
        clear_mon(); tx_q = '{8'h2D, 8'h00, 8'h11}; send_pkt(-1); settle();
        check_val("setup_bad_err", done_err_a[0], CRC_ERR);
        check_val("setup_bad_len", done_len_a[0], 2);

        // ACK with a stray byte
        clear_mon(); tx_q = '{8'hD2, 8'h55}; send_pkt(-1); settle();
        check_val("ack_long_err", done_err_a[0], 4);

        // DATA0 zero-length
        clear_mon(); tx_q = '{8'hC3, 8'h00, 8'h00}; send_pkt(-1); settle();
        check_val("zlp_valid_cnt", rx_q.size(), 0);
        check_val("zlp_sop_cnt", sop_cnt, 0);
        check_val("zlp_len", done_len_a[0], 0);
        check_val("zlp_err", done_err_a[0], 0);

        // DATA1 with 64 payload bytes and a bench-computed CRC16
        crc = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            pay[i] = 8'((i * 37 + 5) & 255);
            for (int b = 0; b < 8; b++) begin
                fb  = crc[15] ^ pay[i][b];
                crc = {crc[14:0], 1'b0};
                if (fb) crc = crc ^ 16'h8005;
            end
        end
        crc = ~crc;
        for (int b = 0; b < 8; b++) begin
            c0[b] = crc[15 - b];
            c1[b] = crc[7 - b];
        end
        clear_mon();
        tx_q.delete();
        tx_q.push_back(8'h4B);
        for (int i = 0; i < 64; i++) tx_q.push_back(pay[i]);
        tx_q.push_back(c0);
        tx_q.push_back(c1);
        send_pkt(-1); settle();
        check_val("d64_cnt", rx_q.size(), 64);
        if (rx_q.size() == 64) begin
            for (int i = 0; i < 64; i++) check_val($sformatf("d64_b%0d", i), int'(rx_q[i]), int'(pay[i]));
        end
        check_val("d64_len", done_len_a[0], 64);
        check_val("d64_err", done_err_a[0], 0);
        check_val("d64_sop_cnt", sop_cnt, 1);
        check_val("d64_valid_lat", first_valid_cyc, drive_cyc[3] + 1);
        check_val("d64_late", late_cnt, 0);
        check_val("d64_pid", int'(pkt_pid), 4'hB);

        // Bad PID
        clear_mon(); tx_q = '{8'hC5, 8'h11, 8'h22, 8'h33}; send_pkt(-1); settle();
        check_val("badpid_err", done_err_a[0], 2);
        check_val("badpid_valid_cnt", rx_q.size(), 0);
        check_val("badpid_done_cnt", done_cnt, 1);
        check_val("badpid_pidv_cnt", pidv_cnt, 0);

        // PHY error on the fifth byte of a DATA0 packet
        clear_mon(); tx_q = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; send_pkt(4); settle();
        check_val("rxerr_err", done_err_a[0], 1);
        check_val("rxerr_cnt", rx_q.size(), 1);
        if (rx_q.size() == 1) check_val("rxerr_b0", int'(rx_q[0]), 8'h01);
        check_val("rxerr_len", done_len_a[0], 1);

        // Overflow on the MAX_BYTES=8 instance
        clear_mon();
        tx_q = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_pkt(-1); settle();
        check_val("ovf_done_cnt", d8_done_cnt, 1);
        check_val("ovf_err", d8_err_last, 4);
        check_val("ovf_len", d8_len_last, 5);

        // Reset mid-packet, released with rxactive still high
        clear_mon();
        @(posedge clk); #1;
        utmirxactive = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        utmirxvalid = 1'b1;
        utmidatao   = 16'h002D;
        @(posedge clk); #1;
        utmidatao   = 16'h0000;
        @(posedge clk); #1;
        utmirxvalid = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        utmirxvalid = 1'b1;
        utmidatao   = 16'h0010;
        @(posedge clk); #1;
        utmirxvalid = 1'b0;
        @(posedge clk); #1;
        utmirxactive = 1'b0;
        settle();
        check_val("rstmid_pid", int'(pkt_pid), 0);
        check_val("rstmid_done_cnt", done_cnt, 0);
        check_val("rstmid_valid_cnt", rx_q.size(), 0);
        check_val("rstmid_pidv_cnt", pidv_cnt, 0);

        // Back-to-back ACK then SETUP with one idle cycle between
        clear_mon();
        tx_q = '{8'hD2}; send_pkt(-1);
        tx_q = '{8'h2D, 8'h00, 8'h10}; send_pkt(-1);
        settle();
        check_val("b2b_done_cnt", done_cnt, 2);
        check_val("b2b_len0", done_len_a[0], 0);
        check_val("b2b_err0", done_err_a[0], 0);
        check_val("b2b_len1", done_len_a[1], 2);
        check_val("b2b_err1", done_err_a[1], 0);
        check_val("b2b_cnt", rx_q.size(), 2);
        if (rx_q.size() == 2) check_val("b2b_b1", int'(rx_q[1]), 8'h10);
        check_val("b2b_pid", int'(pkt_pid), 4'hD);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/brt_usb_20_utmi_rx_pkt.md
# brt_usb_20_utmi_rx_pkt

Receive-side packet decoder sitting directly downstream of the UTMI PHY interface (`brt_usb_20_utmi_if`) in the USB 2.0 VIP/design. It consumes the UTMI receive byte stream (`utmidatao`, `utmirxvalid`, `utmirxactive`, `utmirxerror`), checks the PID, classifies the packet and checks its length and CRC. It forwards payload bytes to the link/protocol layer, stripping the trailing CRC16 bytes of data packets. At packet end it reports PID, length and error status.

## Interface
- `MAX_BYTES`, 1027: max bytes per packet including PID and CRC (1 + 1024 + 2).
- `LEN_W`, 11: width of `pkt_len`.
- `clk_utmi` in 1: UTMI clock; all logic in this single domain.
- `rst_utmi` in 1: reset, synchronous, active-high.
- `utmidatao` in 16: receive data; 8-bit UTMI mode, only [7:0] used, [15:8] ignored.
- `utmirxvalid` in 1: byte on `utmidatao[7:0]` is valid.
- `utmirxactive` in 1: packet in progress.
- `utmirxerror` in 1: PHY receive error.
- `pkt_valid` out 1: payload byte strobe. There is no backpressure.
- `pkt_data` out 8: payload byte.
- `pkt_sop` out 1: first payload byte of the packet; qualified by `pkt_valid`.
- `pkt_pid_valid` out 1: one-cycle pulse; `pkt_pid` updated.
- `pkt_pid` out 4: PID[3:0]; held until the next PID.
- `pkt_done` out 1: one-cycle end-of-packet pulse.
- `pkt_len` out LEN_W: forwarded payload byte count; valid with `pkt_done`, then held.
- `pkt_err` out 4: error bits, valid with `pkt_done`, then held. Bit 0 = rx, bit 1 = pid, bit 2 = len, bit 3 = crc.

## Operation
- FSM states: IDLE, PID, BODY, DRAIN, DONE.
- IDLE → PID on a rising edge of `utmirxactive`.
  - The registered copy of `rxactive` resets to 1, so a packet already in progress at reset release is ignored.
- PID state, first accepted byte:
  - Check: [3:0] == ~[7:4]. If the check fails, set `err[1]` and go to DRAIN.
  - If the check passes, latch the PID, pulse `pkt_pid_valid`, and go to BODY.
  - If `rxactive` falls in PID state: set `err[2]`, go to DONE.
- Accepted byte: `utmirxvalid` & `utmirxactive` & !`utmirxerror`.
  - A byte with `rxvalid` while `rxactive`=0 is ignored.
- `utmirxerror` sampled high while `rxactive` in PID/BODY: set `err[0]`, discard that byte, stop forwarding, go to DRAIN.
- Byte counter (including PID):
  - An accepted byte that would exceed `MAX_BYTES` sets `err[2]` and sends the FSM to DRAIN.
  - The counter saturates.
- Classes by PID[3:0]:
  - Data (3, B, 7, F):
    - All bytes go through a 2-byte hold register. A byte is forwarded only when a newer byte is accepted.
    - The final two bytes are the CRC16 and are never forwarded.
    - Fewer than 2 bytes after the PID sets `err[2]`.
  - Token (1, 9, 5, D, 4):
    - Exactly 2 bytes after the PID, else `err[2]`.
    - The bytes are forwarded unmodified.
  - Handshake (2, A, E, 6): 0 bytes after the PID, else `err[2]`.
  - Other (C, 8, 0): forwarded unmodified; no length or CRC checks.
- CRC:
  - Bits are fed LSB-first per byte, over all bytes after the PID.
  - CRC5: poly x^5+x^2+1, init 5'h1F, good residual 5'h0C.
  - CRC16: poly 16'h8005, init 16'hFFFF, good residual 16'h800D.
  - A mismatch at the end sets `err[3]`.
  - CRC5 is checked for the token class, CRC16 for the data class.
- BODY/DRAIN → DONE when `rxactive` is sampled low.
- DONE: pulse `pkt_done`, publish `pkt_len`/`pkt_err`, go to IDLE.
  - A new rising edge of `rxactive` in DONE is honoured on the next cycle from IDLE.
- Reset values:
  - All outputs 0 and FSM in IDLE.
  - Hold register, counters, CRC and error accumulators cleared.
  - Reset mid-packet drops the packet with no `pkt_done`.

## Timing
- Token/other class: `pkt_valid` one cycle after the byte is accepted.
- Data class: payload byte k is output one cycle after byte k+2 is accepted.
- `pkt_pid_valid`: one cycle after the PID byte is accepted.
- `pkt_done`: one cycle after the cycle in which `rxactive` is sampled low.
  - No `pkt_valid` for the packet occurs in or after `pkt_done`.
- `pkt_sop` coincides with the first `pkt_valid` of the packet. A packet with no payload gives no `pkt_sop`.

## Configuration
- `BRT_USB_20_UTMI_RX_CRC_EN`:
  - Defined: CRC5/CRC16 checkers are compiled in and `err[3]` is active.
  - Undefined: no CRC logic and `err[3]` is tied to 0.
  - Length checks and CRC16 byte stripping are unchanged either way.

## Structure
- Package `brt_usb_20_utmi_rx_pkg` holds:
  - PID enum and class decode function.
  - FSM state typedef.
  - `pkt_err` bit index constants.
  - CRC polynomials, inits and residuals.
- Sub-module `brt_usb_20_crc_step`:
  - Combinational byte-wide LFSR update with parameters WIDTH, POLY.
  - Instantiated twice: 5-bit and 16-bit.

## Test plan
- ACK: byte D2 → `pkt_pid`=2, `pkt_len`=0, `pkt_err`=0, no `pkt_valid`.
- SETUP token: 2D 00 10 → forwards 00 then 10 with `pkt_sop` on 00; `pkt_len`=2, `pkt_err`=0. Corrupt 10→11 → `err[3]`; with the macro undefined, `err`=0.
- DATA0 zero-length: C3 00 00 → no `pkt_valid`, `pkt_len`=0, `err`=0. Bench-generated 64-byte DATA1 packet → 64 bytes forwarded, CRC bytes stripped, `err`=0.
- Bad PID C5 then 3 bytes → `err[1]`, no `pkt_valid`, `pkt_done` once. `utmirxerror` on byte 5 of a DATA0 packet → `err[0]`, at most 2 bytes forwarded.
- `MAX_BYTES`=8 with a 10-byte DATA0 → `err[2]`, `pkt_len` ≤ 6, single `pkt_done`.
- Reset asserted mid-packet, released with `rxactive` still high → no outputs for that packet. Two back-to-back packets with one idle cycle both decode correctly.
